// File: rtl/mandel_pixel_sequencer.sv
// Mandelbrot pixel sequencer: walks the frame in raster order, hands each
// pixel's complex coordinate to the iteration core, and forwards the
// resulting iteration count with sof/eol framing over valid/ready.
// Frame configuration is captured once per frame so register writes never tear a frame.
module mandel_pixel_sequencer #(
    parameter int X_SIZE  = 640,
    parameter int Y_SIZE  = 480,
    parameter int COORD_W = 32,
    parameter int ITER_W  = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               enable_i,
    input  logic [COORD_W-1:0] cfg_x_min_i,
    input  logic [COORD_W-1:0] cfg_y_max_i,
    input  logic [COORD_W-1:0] cfg_step_i,
    input  logic [ITER_W-1:0]  cfg_max_iter_i,
    output logic               core_start_o,
    output logic [COORD_W-1:0] core_x0_o,
    output logic [COORD_W-1:0] core_y0_o,
    output logic [ITER_W-1:0]  core_max_iter_o,
    input  logic [ITER_W-1:0]  core_iter_i,
    input  logic               core_done_i,
    output logic [ITER_W-1:0]  pix_iter_o,
    output logic               pix_sof_o,
    output logic               pix_eol_o,
    output logic               pix_valid_o,
    input  logic               pix_ready_i,
    output logic               frame_done_o,
    output logic               busy_o
);

    localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
    localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_START   = 3'd2,
        S_WAIT    = 3'd3,
        S_EMIT    = 3'd4,
        S_ADVANCE = 3'd5
    } state_e;

    state_e               state_q, state_d;
    logic [XW-1:0]        x_q, x_d;
    logic [YW-1:0]        y_q, y_d;
    logic [COORD_W-1:0]   x0_q, x0_d;
    logic [COORD_W-1:0]   y0_q, y0_d;
    logic [COORD_W-1:0]   x_min_q, x_min_d;
    logic [COORD_W-1:0]   step_q, step_d;
    logic [ITER_W-1:0]    max_iter_q, max_iter_d;
    logic [ITER_W-1:0]    iter_q, iter_d;
    logic                 start_q, start_d;
    logic                 valid_q, valid_d;
    logic                 sof_q, sof_d;
    logic                 eol_q, eol_d;
    logic                 frame_done_q, frame_done_d;
    logic                 busy_q, busy_d;

    // Next-state and datapath update; all flag outputs are derived from the
    // upcoming state so they line up with the state they describe.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        x_min_d    = x_min_q;
        step_d     = step_q;
        max_iter_d = max_iter_q;
        iter_d     = iter_q;

        case (state_q)
            S_IDLE: begin
                if (enable_i) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                x_min_d    = cfg_x_min_i;
                step_d     = cfg_step_i;
                max_iter_d = cfg_max_iter_i;
                x_d        = '0;
                y_d        = '0;
                x0_d       = cfg_x_min_i;
                y0_d       = cfg_y_max_i;
                state_d    = S_START;
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Done pulses outside WAIT never reach this capture.
                if (core_done_i) begin
                    iter_d  = core_iter_i;
                    state_d = S_EMIT;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_EMIT: begin
                if (valid_q && pix_ready_i) begin
                    state_d = S_ADVANCE;
                end else begin
                    state_d = S_EMIT;
                end
            end
            S_ADVANCE: begin
                if (x_q != X_LAST) begin
                    x_d     = x_q + XW'(1);
                    x0_d    = x0_q + step_q;
                    state_d = S_START;
                end else if (y_q != Y_LAST) begin
                    x_d     = '0;
                    y_d     = y_q + YW'(1);
                    x0_d    = x_min_q;
                    y0_d    = y0_q - step_q;
                    state_d = S_START;
                end else if (enable_i) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        start_d      = (state_d == S_START);
        valid_d      = (state_d == S_EMIT);
        sof_d        = valid_d && (x_d == '0) && (y_d == '0);
        eol_d        = valid_d && (x_d == X_LAST);
        busy_d       = (state_d != S_IDLE);
        frame_done_d = (state_d == S_ADVANCE) && (x_q == X_LAST) && (y_q == Y_LAST);
    end

    // State and output registers with synchronous reset taking priority.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            x0_q         <= '0;
            y0_q         <= '0;
            x_min_q      <= '0;
            step_q       <= '0;
            max_iter_q   <= '0;
            iter_q       <= '0;
            start_q      <= 1'b0;
            valid_q      <= 1'b0;
            sof_q        <= 1'b0;
            eol_q        <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            x0_q         <= x0_d;
            y0_q         <= y0_d;
            x_min_q      <= x_min_d;
            step_q       <= step_d;
            max_iter_q   <= max_iter_d;
            iter_q       <= iter_d;
            start_q      <= start_d;
            valid_q      <= valid_d;
            sof_q        <= sof_d;
            eol_q        <= eol_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign core_start_o    = start_q;
    assign core_x0_o       = x0_q;
    assign core_y0_o       = y0_q;
    assign core_max_iter_o = max_iter_q;
    assign pix_iter_o      = iter_q;
    assign pix_sof_o       = sof_q;
    assign pix_eol_o       = eol_q;
    assign pix_valid_o     = valid_q;
    assign frame_done_o    = frame_done_q;
    assign busy_o          = busy_q;

endmodule

// File: tb/tb_mandel_pixel_sequencer.sv
// Directed bench for mandel_pixel_sequencer on a 4x3 frame with a
// behavioural iteration core that answers with iter = x + 4*y.
module tb_mandel_pixel_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        enable_i = 1'b0;
    logic [31:0] cfg_x_min_i = 32'h0;
    logic [31:0] cfg_y_max_i = 32'h0;
    logic [31:0] cfg_step_i = 32'h0;
    logic [15:0] cfg_max_iter_i = 16'h0;
    logic        core_start_o;
    logic [31:0] core_x0_o;
    logic [31:0] core_y0_o;
    logic [15:0] core_max_iter_o;
    logic [15:0] core_iter_i = 16'h0;
    logic        core_done_i = 1'b0;
    logic [15:0] pix_iter_o;
    logic        pix_sof_o;
    logic        pix_eol_o;
    logic        pix_valid_o;
    logic        pix_ready_i = 1'b0;
    logic        frame_done_o;
    logic        busy_o;

    int total = 0;
    int bad = 0;

    // Q4.28 coordinates for the 4x3 walk with step 0.5 and step 0.25
    logic [31:0] xtab  [4] = '{32'hE000_0000, 32'hE800_0000, 32'hF000_0000, 32'hF800_0000};
    logic [31:0] ytab  [3] = '{32'h1000_0000, 32'h0800_0000, 32'h0000_0000};
    logic [31:0] x2tab [4] = '{32'hE000_0000, 32'hE400_0000, 32'hE800_0000, 32'hEC00_0000};

    // core model state
    int   core_lat = 3;
    int   cd = 0;
    int   idx = 0;
    int   pend = 0;
    bit   spur_req = 1'b0;

    // monitors
    int   fd_cnt = 0;
    int   start_cnt = 0;
    int   cyc = 0;

    mandel_pixel_sequencer #(
        .X_SIZE(4), .Y_SIZE(3), .COORD_W(32), .ITER_W(16)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i),
        .cfg_x_min_i(cfg_x_min_i), .cfg_y_max_i(cfg_y_max_i),
        .cfg_step_i(cfg_step_i), .cfg_max_iter_i(cfg_max_iter_i),
        .core_start_o(core_start_o), .core_x0_o(core_x0_o), .core_y0_o(core_y0_o),
        .core_max_iter_o(core_max_iter_o), .core_iter_i(core_iter_i),
        .core_done_i(core_done_i), .pix_iter_o(pix_iter_o), .pix_sof_o(pix_sof_o),
        .pix_eol_o(pix_eol_o), .pix_valid_o(pix_valid_o), .pix_ready_i(pix_ready_i),
        .frame_done_o(frame_done_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // iteration core model: done core_lat cycles after start, iter = raster index
    always @(negedge clk_i) begin
        core_done_i = 1'b0;
        if (rst_i) idx = 0;
        if (spur_req) begin
            core_done_i = 1'b1;
            core_iter_i = 16'd99;
        end else if (cd > 0) begin
            cd = cd - 1;
            if (cd == 0) begin
                core_done_i = 1'b1;
                core_iter_i = 16'(pend);
            end
        end
        if (core_start_o && !rst_i) begin
            cd   = core_lat;
            pend = idx;
            idx  = (idx == 11) ? 0 : idx + 1;
        end
    end

    // event counters
    always @(negedge clk_i) begin
        if (frame_done_o) fd_cnt = fd_cnt + 1;
        if (core_start_o) start_cnt = start_cnt + 1;
    end

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk_i);
            if (pix_valid_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        enable_i = 1'b0;
        pix_ready_i = 1'b0;
        core_lat = 3;
        cfg_x_min_i = 32'hE000_0000;
        cfg_y_max_i = 32'h1000_0000;
        cfg_step_i = 32'h0800_0000;
        cfg_max_iter_i = 16'd100;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        total++;
        if ({pix_valid_o, core_start_o, busy_o, frame_done_o, pix_sof_o, pix_eol_o} !== 6'b0) begin
            bad++; $display("FAIL reset_flags got=%b exp=000000",
                {pix_valid_o, core_start_o, busy_o, frame_done_o, pix_sof_o, pix_eol_o});
        end
        total++;
        if (core_x0_o !== 32'h0 || core_y0_o !== 32'h0) begin
            bad++; $display("FAIL reset_coord got=%h/%h exp=0/0", core_x0_o, core_y0_o);
        end
        total++;
        if (pix_iter_o !== 16'h0 || core_max_iter_o !== 16'h0) begin
            bad++; $display("FAIL reset_iter got=%h/%h exp=0/0", pix_iter_o, core_max_iter_o);
        end
        rst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        total++;
        if (busy_o !== 1'b0) begin
            bad++; $display("FAIL idle_no_enable busy got=%b exp=0", busy_o);
        end
    endtask

    task automatic test_frame_walk();
        bit ok;
        int fd0;
        do_reset();
        fd0 = fd_cnt;
        enable_i = 1'b1;
        pix_ready_i = 1'b1;
        for (int p = 0; p < 12; p++) begin
            wait_valid(ok);
            total++;
            if (!ok) begin bad++; $display("FAIL walk_timeout pixel=%0d", p); end
            total++;
            if (pix_iter_o !== 16'(p)) begin
                bad++; $display("FAIL walk_iter got=%0d exp=%0d", pix_iter_o, p);
            end
            total++;
            if (pix_sof_o !== (p == 0) || pix_eol_o !== (p % 4 == 3)) begin
                bad++; $display("FAIL walk_flags pixel=%0d got sof=%b eol=%b exp sof=%b eol=%b",
                    p, pix_sof_o, pix_eol_o, (p == 0), (p % 4 == 3));
            end
            total++;
            if (core_x0_o !== xtab[p % 4] || core_y0_o !== ytab[p / 4]) begin
                bad++; $display("FAIL walk_coord pixel=%0d got=%h/%h exp=%h/%h",
                    p, core_x0_o, core_y0_o, xtab[p % 4], ytab[p / 4]);
            end
            if (p == 0) begin
                total++;
                if (core_max_iter_o !== 16'd100 || busy_o !== 1'b1) begin
                    bad++; $display("FAIL walk_maxiter got=%0d busy=%b exp=100 busy=1",
                        core_max_iter_o, busy_o);
                end
            end
        end
        repeat (2) @(negedge clk_i);
        total++;
        if (fd_cnt - fd0 !== 1) begin
            bad++; $display("FAIL walk_frame_done got=%0d exp=1", fd_cnt - fd0);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int s0;
        do_reset();
        enable_i = 1'b1;
        wait_valid(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL bp_timeout"); end
        s0 = start_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            total++;
            if (pix_valid_o !== 1'b1 || pix_iter_o !== 16'd0 || pix_sof_o !== 1'b1 || pix_eol_o !== 1'b0) begin
                bad++; $display("FAIL bp_hold got v=%b it=%0d sof=%b eol=%b exp v=1 it=0 sof=1 eol=0",
                    pix_valid_o, pix_iter_o, pix_sof_o, pix_eol_o);
            end
        end
        total++;
        if (start_cnt !== s0) begin
            bad++; $display("FAIL bp_no_start got=%0d exp=%0d", start_cnt, s0);
        end
        pix_ready_i = 1'b1;
        @(negedge clk_i);
        total++;
        if (pix_valid_o !== 1'b0) begin
            bad++; $display("FAIL bp_release valid got=%b exp=0", pix_valid_o);
        end
        wait_valid(ok);
        total++;
        if (!ok || pix_iter_o !== 16'd1 || start_cnt !== s0 + 1) begin
            bad++; $display("FAIL bp_next got it=%0d starts=%0d exp it=1 starts=%0d",
                pix_iter_o, start_cnt, s0 + 1);
        end
    endtask

    task automatic test_cfg_change();
        bit ok;
        do_reset();
        enable_i = 1'b1;
        pix_ready_i = 1'b1;
        for (int p = 0; p < 12; p++) begin
            wait_valid(ok);
            if (p == 5) cfg_step_i = 32'h0400_0000;
            total++;
            if (!ok || core_x0_o !== xtab[p % 4] || core_y0_o !== ytab[p / 4]) begin
                bad++; $display("FAIL cfg_old pixel=%0d got=%h/%h exp=%h/%h",
                    p, core_x0_o, core_y0_o, xtab[p % 4], ytab[p / 4]);
            end
        end
        for (int p = 0; p < 5; p++) begin
            wait_valid(ok);
            total++;
            if (!ok || pix_iter_o !== 16'(p) || core_x0_o !== x2tab[p % 4] ||
                core_y0_o !== ((p < 4) ? 32'h1000_0000 : 32'h0C00_0000)) begin
                bad++; $display("FAIL cfg_new pixel=%0d got it=%0d x=%h y=%h exp it=%0d x=%h",
                    p, pix_iter_o, core_x0_o, core_y0_o, p, x2tab[p % 4]);
            end
        end
    endtask

    task automatic test_enable_drop();
        bit ok;
        int fd0;
        int s0;
        do_reset();
        fd0 = fd_cnt;
        enable_i = 1'b1;
        pix_ready_i = 1'b1;
        for (int p = 0; p < 12; p++) begin
            wait_valid(ok);
            if (p == 2) enable_i = 1'b0;
            total++;
            if (!ok || pix_iter_o !== 16'(p)) begin
                bad++; $display("FAIL drop_iter got=%0d exp=%0d", pix_iter_o, p);
            end
        end
        repeat (3) @(negedge clk_i);
        s0 = start_cnt;
        total++;
        if (fd_cnt - fd0 !== 1 || busy_o !== 1'b0) begin
            bad++; $display("FAIL drop_idle got fd=%0d busy=%b exp fd=1 busy=0", fd_cnt - fd0, busy_o);
        end
        repeat (10) @(negedge clk_i);
        total++;
        if (start_cnt !== s0 || pix_valid_o !== 1'b0) begin
            bad++; $display("FAIL drop_stays_idle got starts=%0d exp=%0d", start_cnt, s0);
        end
    endtask

    task automatic test_reset_in_wait();
        bit ok;
        do_reset();
        core_lat = 4;
        enable_i = 1'b1;
        pix_ready_i = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (core_start_o) begin ok = 1'b1; break; end
        end
        total++;
        if (!ok) begin bad++; $display("FAIL rw_start_timeout"); end
        @(negedge clk_i);
        rst_i = 1'b1;
        enable_i = 1'b0;
        @(negedge clk_i);
        total++;
        if ({busy_o, core_start_o, pix_valid_o} !== 3'b0 || core_x0_o !== 32'h0 || core_y0_o !== 32'h0) begin
            bad++; $display("FAIL rw_reset got busy=%b x=%h y=%h exp busy=0 x=0 y=0",
                busy_o, core_x0_o, core_y0_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        total++;
        if (busy_o !== 1'b0 || pix_valid_o !== 1'b0 || pix_iter_o !== 16'h0) begin
            bad++; $display("FAIL rw_done_ignored got busy=%b v=%b it=%0d exp 0/0/0",
                busy_o, pix_valid_o, pix_iter_o);
        end
        core_lat = 3;
        enable_i = 1'b1;
        wait_valid(ok);
        total++;
        if (!ok || pix_sof_o !== 1'b1 || pix_iter_o !== 16'd0 ||
            core_x0_o !== 32'hE000_0000 || core_y0_o !== 32'h1000_0000) begin
            bad++; $display("FAIL rw_restart got sof=%b it=%0d x=%h y=%h exp sof=1 it=0",
                pix_sof_o, pix_iter_o, core_x0_o, core_y0_o);
        end
    endtask

    task automatic test_spurious_done();
        bit ok;
        do_reset();
        enable_i = 1'b1;
        wait_valid(ok);
        @(posedge clk_i); #1 spur_req = 1'b1;
        @(posedge clk_i); #1 spur_req = 1'b0;
        @(negedge clk_i);
        total++;
        if (!ok || pix_valid_o !== 1'b1 || pix_iter_o !== 16'd0) begin
            bad++; $display("FAIL spur_hold got v=%b it=%0d exp v=1 it=0", pix_valid_o, pix_iter_o);
        end
        pix_ready_i = 1'b1;
        for (int p = 1; p < 4; p++) begin
            wait_valid(ok);
            total++;
            if (!ok || pix_iter_o !== 16'(p)) begin
                bad++; $display("FAIL spur_seq got=%0d exp=%0d", pix_iter_o, p);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int t0;
        int t1;
        do_reset();
        core_lat = 1;
        enable_i = 1'b1;
        pix_ready_i = 1'b1;
        wait_valid(ok);
        t0 = cyc;
        for (int p = 1; p < 4; p++) begin
            wait_valid(ok);
            t1 = cyc;
            total++;
            if (!ok || t1 - t0 !== 4 || pix_iter_o !== 16'(p)) begin
                bad++; $display("FAIL b2b_spacing got=%0d it=%0d exp=4 it=%0d", t1 - t0, pix_iter_o, p);
            end
            t0 = t1;
        end
    endtask

    initial begin
        test_reset();
        test_frame_walk();
        test_backpressure();
        test_cfg_change();
        test_enable_drop();
        test_reset_in_wait();
        test_spurious_done();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
